calc_result_collector: RTL and testbench

- Downstream stage of the stack calculator. Samples the calculator's result and status outputs every ck.
- Packs each completion or error event into a record and buffers it in a DEPTH-entry FIFO. Host/scoreboard logic drains the FIFO over a valid/ready read port.
- Keeps saturating event statistics and flags records lost to FIFO overflow.

---
 rtl/calc_result_collector.sv | 105 ++++++++++
 tb/tb_calc_result_collector.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/calc_result_collector.sv
// Result collector for the stack calculator: packs completion/error events into
// records, buffers them in a FIFO for a valid/ready reader, and keeps saturating statistics.
module calc_result_collector #(
  parameter int DEPTH = 8,
  parameter int SEQ_W = 8,
  parameter int CNT_W = 16
) (
  input  logic                       ck,
  input  logic                       rst,
  input  logic [15:0]                result,
  input  logic                       stackOverflow,
  input  logic                       unexpectedDone,
  input  logic                       dataOverflow,
  input  logic                       protocolError,
  input  logic                       correct,
  input  logic                       finished,
  input  logic                       clr_stats,
  input  logic                       rd_ready,
  output logic                       rd_valid,
  output logic [SEQ_W-1:0]           rd_seq,
  output logic [4:0]                 rd_status,
  output logic [15:0]                rd_result,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       full,
  output logic                       lost,
  output logic [CNT_W-1:0]           n_correct,
  output logic [CNT_W-1:0]           n_error,
  output logic [CNT_W-1:0]           n_dropped
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH+1);

  typedef struct packed {
    logic [SEQ_W-1:0] seq;
    logic [4:0]       status;
    logic [15:0]      result;
  } rec_t;

  rec_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level_q;
  logic [SEQ_W-1:0] seq_q;

  logic [4:0] status_in;
  logic       err_in;
  logic       ev;
  logic       pop;
  logic       push;
  logic       drop;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic inc);
    return (inc && (c != '1)) ? c + CNT_W'(1) : c;
  endfunction

  // Read handshake: the head record transfers on a posedge where rd_valid and
  // rd_ready are both high; rd_* hold steady while rd_valid=1 and rd_ready=0.
  always_comb begin
    status_in = {correct, stackOverflow, unexpectedDone, dataOverflow, protocolError};
    err_in    = stackOverflow | unexpectedDone | dataOverflow | protocolError;
    ev        = finished | correct | err_in;
    pop       = rd_valid & rd_ready;
    push      = ev & ((level_q < LVL_W'(DEPTH)) | pop);
    drop      = ev & ~push;
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level_q   <= '0;
      seq_q     <= '0;
      lost      <= 1'b0;
      n_correct <= '0;
      n_error   <= '0;
      n_dropped <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{seq: seq_q, status: status_in, result: result};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      level_q <= level_q + 1'b1;
      else if (pop && !push) level_q <= level_q - 1'b1;
      if (ev) seq_q <= seq_q + 1'b1;
      // Clear takes effect first, so a same-cycle event still counts.
      n_correct <= sat_inc(clr_stats ? '0 : n_correct, correct);
      n_error   <= sat_inc(clr_stats ? '0 : n_error, err_in);
      n_dropped <= sat_inc(clr_stats ? '0 : n_dropped, drop);
      lost      <= (lost & ~clr_stats) | drop;
    end
  end

  always_comb begin
    rd_valid  = (level_q != '0);
    rd_seq    = mem[rd_ptr].seq;
    rd_status = mem[rd_ptr].status;
    rd_result = mem[rd_ptr].result;
    level     = level_q;
    full      = (level_q == LVL_W'(DEPTH));
  end

endmodule

// File: tb/tb_calc_result_collector.sv
// Self-checking bench for calc_result_collector: directed scenarios plus random
// traffic, all compared against a queue-based behavioural model.
module tb_calc_result_collector;

  localparam int DEPTH = 8;
  localparam int SEQ_W = 8;
  localparam int CNT_W = 16;
  localparam int CMAX  = (1 << CNT_W) - 1;
  localparam int SMOD  = 1 << SEQ_W;

  logic        ck = 1'b0;
  logic        rst;
  logic [15:0] result;
  logic        stackOverflow, unexpectedDone, dataOverflow, protocolError, correct, finished;
  logic        clr_stats, rd_ready;
  logic        rd_valid;
  logic [SEQ_W-1:0] rd_seq;
  logic [4:0]  rd_status;
  logic [15:0] rd_result;
  logic [$clog2(DEPTH+1)-1:0] level;
  logic        full, lost;
  logic [CNT_W-1:0] n_correct, n_error, n_dropped;

  calc_result_collector #(.DEPTH(DEPTH), .SEQ_W(SEQ_W), .CNT_W(CNT_W)) dut (
    .ck(ck), .rst(rst), .result(result),
    .stackOverflow(stackOverflow), .unexpectedDone(unexpectedDone),
    .dataOverflow(dataOverflow), .protocolError(protocolError),
    .correct(correct), .finished(finished), .clr_stats(clr_stats),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_seq(rd_seq),
    .rd_status(rd_status), .rd_result(rd_result), .level(level),
    .full(full), .lost(lost), .n_correct(n_correct), .n_error(n_error),
    .n_dropped(n_dropped)
  );

  // clock/reset block
  always #5 ck = ~ck;

  // model state: expected record queue (seq, status, result packed) + stats
  logic [SEQ_W+5+16-1:0] exp_q[$];
  int m_seq, m_correct, m_error, m_dropped;
  bit m_lost;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  task automatic model_step();
    logic [4:0] st;
    bit ev, err, pop, room;
    if (rst) begin
      exp_q.delete();
      m_seq = 0; m_correct = 0; m_error = 0; m_dropped = 0; m_lost = 0;
      return;
    end
    st   = {correct, stackOverflow, unexpectedDone, dataOverflow, protocolError};
    err  = (st[3:0] != 0);
    ev   = finished || (st != 0);
    pop  = (exp_q.size() != 0) && rd_ready;
    room = (exp_q.size() < DEPTH) || pop;
    if (clr_stats) begin
      m_correct = 0; m_error = 0; m_dropped = 0; m_lost = 0;
    end
    if (pop) void'(exp_q.pop_front());
    if (ev) begin
      m_correct = sat(m_correct + int'(correct));
      m_error   = sat(m_error + int'(err));
      if (room) exp_q.push_back({SEQ_W'(m_seq), st, result});
      else begin
        m_dropped = sat(m_dropped + 1);
        m_lost    = 1;
      end
      m_seq = (m_seq + 1) % SMOD;
    end
  endtask

  task automatic compare_all();
    logic [SEQ_W+5+16-1:0] h;
    check_eq("rd_valid", rd_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      h = exp_q[0];
      check_eq("rd_seq", rd_seq, h[SEQ_W+20:21]);
      check_eq("rd_status", rd_status, h[20:16]);
      check_eq("rd_result", rd_result, h[15:0]);
    end
    check_eq("level", level, exp_q.size());
    check_eq("full", full, exp_q.size() == DEPTH);
    check_eq("lost", lost, m_lost);
    check_eq("n_correct", n_correct, m_correct);
    check_eq("n_error", n_error, m_error);
    check_eq("n_dropped", n_dropped, m_dropped);
  endtask

  // driver: called at a negedge; applies one cycle of inputs, updates model, checks
  task automatic drive(input logic [4:0] st, input logic fin, input logic [15:0] res,
                       input logic rdy, input logic clr, input logic r);
    {correct, stackOverflow, unexpectedDone, dataOverflow, protocolError} = st;
    finished = fin; result = res; rd_ready = rdy; clr_stats = clr; rst = r;
    @(posedge ck);
    model_step();
    @(negedge ck);
    compare_all();
  endtask

  task automatic do_reset();
    drive(5'b0, 0, 16'h0, 0, 0, 1);
    drive(5'b0, 0, 16'h0, 0, 0, 0);
  endtask

  initial begin
    rst = 1; result = 0; rd_ready = 0; clr_stats = 0; finished = 0;
    {correct, stackOverflow, unexpectedDone, dataOverflow, protocolError} = 5'b0;
    @(negedge ck);
    do_reset();
    check_eq("reset_level", level, 0);
    check_eq("reset_valid", rd_valid, 0);

    // single good completion
    drive(5'b10000, 1, 16'h000B, 0, 0, 0);
    check_eq("t1_seq", rd_seq, 0);
    check_eq("t1_status", rd_status, 5'b10000);
    check_eq("t1_result", rd_result, 16'h000B);
    check_eq("t1_ncorrect", n_correct, 1);

    // two error records, then drain
    do_reset();
    drive(5'b00001, 0, 16'h0000, 0, 0, 0);
    drive(5'b00100, 1, 16'h0002, 0, 0, 0);
    check_eq("t2_nerror", n_error, 2);
    check_eq("t2_status0", rd_status, 5'b00001);
    drive(5'b0, 0, 16'h0, 1, 0, 0);
    check_eq("t2_seq1", rd_seq, 1);
    check_eq("t2_status1", rd_status, 5'b00100);
    drive(5'b0, 0, 16'h0, 1, 0, 0);
    check_eq("t2_empty", rd_valid, 0);

    // overflow: 10 events into 8 entries
    do_reset();
    for (int i = 0; i < 10; i++) drive(5'b10000, 1, 16'(i), 0, 0, 0);
    check_eq("t3_full", full, 1);
    check_eq("t3_dropped", n_dropped, 2);
    check_eq("t3_lost", lost, 1);
    for (int i = 0; i < 8; i++) begin
      check_eq("t3_drain_seq", rd_seq, i);
      drive(5'b0, 0, 16'h0, 1, 0, 0);
    end
    check_eq("t3_drained", rd_valid, 0);

    // full FIFO with same-cycle pop and push
    for (int i = 0; i < 8; i++) drive(5'b00010, 1, 16'h1000 + 16'(i), 0, 0, 0);
    drive(5'b01000, 1, 16'hBEEF, 1, 0, 0);
    check_eq("t4_level", level, 8);
    check_eq("t4_dropped", n_dropped, 2);

    // 300 events, continuous drain, sequence wraps
    do_reset();
    for (int i = 0; i < 300; i++)
      drive(5'($urandom_range(0, 31)), 1, 16'($urandom), 1, 0, 0);
    drive(5'b00010, 1, 16'h0005, 1, 1, 0);
    check_eq("t5_nerror", n_error, 1);
    check_eq("t5_ncorrect", n_correct, 0);
    check_eq("t5_lost", lost, 0);

    // reset mid-burst
    for (int i = 0; i < 6; i++) drive(5'b10000, 1, 16'(i), 0, 0, 0);
    drive(5'b0, 0, 16'h0, 1, 0, 0);
    drive(5'b0, 0, 16'h0, 1, 0, 1);
    check_eq("t6_valid", rd_valid, 0);
    check_eq("t6_ncorrect", n_correct, 0);
    drive(5'b10000, 1, 16'h0077, 0, 0, 0);
    check_eq("t6_seq", rd_seq, 0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [4:0] st;
      logic fin;
      st = 0; fin = 0;
      if ($urandom_range(0, 99) < 60) begin
        st  = 5'($urandom_range(0, 31));
        fin = 1'($urandom_range(0, 1));
        if (st == 0 && !fin) fin = 1;
      end
      drive(st, fin, 16'($urandom), $urandom_range(0, 99) < 45,
            $urandom_range(0, 99) < 3, $urandom_range(0, 199) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
